// File: rtl/mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_arbiter
// Description : Round-robin arbiter that owns the select of a 4:1 bit mux.
//               Grants one of four requesters, holds the grant until the
//               requester drops its request, and re-arbitrates on release
//               without an idle bubble. Optional forced rotation after
//               MAX_HOLD cycles is enabled by defining MUX4_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_arbiter #(
    parameter int MAX_HOLD = 8          // legal range 2..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] in,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       out
);

    // Saturation point of the hold counter; also the preemption threshold.
    localparam logic [7:0] c_hold_max = 8'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_grant;
    logic [3:0]  w_grant_nxt;
    logic [1:0]  r_sel;
    logic [1:0]  w_sel_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic [1:0]  r_last;
    logic [1:0]  w_last_nxt;
    logic [7:0]  r_hold_cnt;
    logic [7:0]  w_hold_nxt;

    logic [3:0]  w_others;      // pending requests other than the current owner
    logic        w_release;     // current owner has dropped its request
    logic        w_timeout;     // owner has used up its hold budget while others wait

    // Round-robin search: candidates last+1, last+2, last+3, last (mod 4).
    // Iterating from lowest to highest priority lets the highest-priority
    // hit overwrite earlier ones. Caller checks |r before using the result.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] res;
        res = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) begin
                res = idx;
            end
        end
        return res;
    endfunction

    assign w_others  = req & ~(4'b0001 << r_sel);
    assign w_release = ~req[r_sel];

`ifdef MUX4_ARB_TIMEOUT_EN
    assign w_timeout = (r_hold_cnt == c_hold_max) && (|w_others);
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output computation for the two-state arbiter.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_busy_nxt  = r_busy;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold_cnt;

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_sel_nxt   = rr_pick(req, r_last);
                    w_last_nxt  = w_sel_nxt;
                    w_grant_nxt = 4'b0001 << w_sel_nxt;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = 8'd0;
                    w_state_nxt = S_GRANT;
                end
            end

            S_GRANT: begin
                if (w_release || w_timeout) begin
                    if (|w_others) begin
                        // Owner is excluded by the mask; a requester that
                        // dropped and re-raised competes again next time.
                        w_sel_nxt   = rr_pick(w_others, r_last);
                        w_last_nxt  = w_sel_nxt;
                        w_grant_nxt = 4'b0001 << w_sel_nxt;
                        w_hold_nxt  = 8'd0;
                    end else begin
                        // Only reachable on release: timeout needs a waiter.
                        // sel is kept so the mux input stays stable.
                        w_grant_nxt = 4'b0000;
                        w_busy_nxt  = 1'b0;
                        w_hold_nxt  = 8'd0;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    if (r_hold_cnt != c_hold_max) begin
                        w_hold_nxt = r_hold_cnt + 8'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; last=3 gives requester 0 first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= 4'b0000;
            r_sel      <= 2'd0;
            r_busy     <= 1'b0;
            r_last     <= 2'd3;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_sel      <= w_sel_nxt;
            r_busy     <= w_busy_nxt;
            r_last     <= w_last_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;
    assign busy  = r_busy;

    // Data path: zero-latency mux, forced low while idle.
    assign out = r_busy ? in[r_sel] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_arbiter
// Description : Directed self-checking bench for mux4_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] in;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       out;

    int n_checks = 0;
    int n_fail   = 0;

    mux4_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .in    (in),
        .grant (grant),
        .sel   (sel),
        .busy  (busy),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] es,
                       input logic eb, input logic eo);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {grant, sel, busy, out};
        exp = {eg, es, eb, eo};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: grant/sel/busy/out observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        in  = 4'b0000;
        tick();
        tick();
        chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle%0d", i), 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        // Round robin 0,1,2,3,0 with 2-cycle grants and no gaps
        req = 4'b1111;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr%0d_a", i), 4'(1 << i), 2'(i), 1'b1, 1'b0);
            tick();
            chk($sformatf("rr%0d_b", i), 4'(1 << i), 2'(i), 1'b1, 1'b0);
            req = 4'b1111 & ~4'(1 << i);
            tick();
            req = 4'b1111;
        end
        chk("rr_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk("rr_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single requester 2, data path follows in combinationally
        req = 4'b0100;
        in  = 4'b0100;
        tick();
        chk("mux_sel2", 4'b0100, 2'd2, 1'b1, 1'b1);
        in = 4'b0000;
        #1;
        chk("mux_in0", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk("release_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        in = 4'b1111;
        #1;
        chk("idle_out0", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Reset while requester 1 holds the grant
        req = 4'b0010;
        tick();
        chk("pre_rst_g1", 4'b0010, 2'd1, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk("post_rst_g1", 4'b0010, 2'd1, 1'b1, 1'b1);
        req = 4'b0000;
        tick();
        chk("post_rst_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

        // Two requesters held constantly: timeout rotation or indefinite hold
        in  = 4'b0000;
        req = 4'b0011;
        tick();
`ifdef MUX4_ARB_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            if (((k / 4) % 2) == 0)
                chk($sformatf("to%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
            else
                chk($sformatf("to%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
            tick();
        end
`else
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("hold%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
            tick();
        end
`endif
        req = 4'b0000;
        tick();
        chk("hold_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Requester 3 releases while 0 raises, then 3 re-requests
        in  = 4'b1001;
        req = 4'b1000;
        tick();
        chk("g3_a", 4'b1000, 2'd3, 1'b1, 1'b1);
        tick();
        chk("g3_b", 4'b1000, 2'd3, 1'b1, 1'b1);
        req = 4'b0001;
        tick();
        chk("g0_after3", 4'b0001, 2'd0, 1'b1, 1'b1);
        req = 4'b1001;
        tick();
        chk("g0_hold_a", 4'b0001, 2'd0, 1'b1, 1'b1);
        tick();
        chk("g0_hold_b", 4'b0001, 2'd0, 1'b1, 1'b1);
        req = 4'b1000;
        tick();
        chk("g3_again", 4'b1000, 2'd3, 1'b1, 1'b1);
        req = 4'b0000;
        tick();
        chk("final_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
